// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Optional saturation on overflow: define BCD2BIN_SAT_EN.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         BCD_DIG_W   = 4;
  localparam logic [3:0] BCD_MAX_DIG = 4'd9;
  localparam logic [3:0] BCD_ADJ_THR = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB = 4'd3;

  function automatic logic bcd_nib_bad(
    input logic [3:0] d
  );
    return d > BCD_MAX_DIG;
  endfunction

endpackage

// File: rtl/bcd2bin_seq_adj.sv
// Per-digit correction for one reverse double-dabble step:
// a digit that picked up the 8 weight from its upper neighbour loses 3.
module bcd_digit_adj
  import bcd2bin_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= BCD_ADJ_THR) ? d_i - BCD_ADJ_SUB : d_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one shift/adjust step per clock.
// Optional saturation on overflow: define BCD2BIN_SAT_EN.
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int NDIG  = 3,
  parameter int BIN_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BCD_DIG_W*NDIG-1:0] bcd_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIN_W-1:0]          bin_out,
  output logic                      err_digit,
  output logic                      err_ovf
);

  localparam int BCD_W = BCD_DIG_W * NDIG;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   res_q, res_d;
  logic               edig_q, edig_d;
  logic               eovf_q, eovf_d;

  logic [BCD_W-1:0]   bcd_sh;
  logic [BIN_W-1:0]   bin_sh;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   ovf_res;
  logic               dig_bad;
  logic               ovf_now;

  // One right shift of the combined {bcd,bin} register
  assign {bcd_sh, bin_sh} = {bcd_q, bin_q} >> 1;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_sh[g*BCD_DIG_W +: BCD_DIG_W]),
      .d_o (bcd_adj[g*BCD_DIG_W +: BCD_DIG_W])
    );
  end

  // Any residual decimal weight means the value did not fit
  assign ovf_now = |bcd_adj;

`ifdef BCD2BIN_SAT_EN
  assign ovf_res = {BIN_W{1'b1}};
`else
  assign ovf_res = bin_sh;
`endif

  // Flag input nibbles outside 0..9
  always_comb begin
    dig_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_nib_bad(bcd_in[i*BCD_DIG_W +: BCD_DIG_W])) begin
        dig_bad = 1'b1;
      end
    end
  end

  // Next-state and datapath updates for the IDLE/SHIFT/DONE sequence
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    edig_d  = edig_q;
    eovf_d  = eovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d   = bcd_in;
          bin_d   = '0;
          cnt_d   = '0;
          edig_d  = dig_bad;
          eovf_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          eovf_d  = !edig_q && ovf_now;
          if (edig_q) begin
            res_d = '0;
          end else if (ovf_now) begin
            res_d = ovf_res;
          end else begin
            res_d = bin_sh;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shift registers and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      edig_q  <= 1'b0;
      eovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      edig_q  <= edig_d;
      eovf_q  <= eovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bin_out   = res_q;
  assign err_digit = edig_q;
  assign err_ovf   = eovf_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed plus random checks of bcd2bin_seq at BIN_W=10 and BIN_W=8.
// Expectations follow BCD2BIN_SAT_EN when defined.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] bcd_in = '0;
  logic        out_ready = 1'b0;

  logic        ir_a, ov_a, ed_a, eo_a;
  logic [9:0]  bin_a;
  logic        ir_b, ov_b, ed_b, eo_b;
  logic [7:0]  bin_b;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd2bin_seq #(.NDIG(3), .BIN_W(10)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & ~sel),
    .in_ready  (ir_a),
    .bcd_in    (bcd_in),
    .out_valid (ov_a),
    .out_ready (out_ready & ~sel),
    .bin_out   (bin_a),
    .err_digit (ed_a),
    .err_ovf   (eo_a)
  );

  bcd2bin_seq #(.NDIG(3), .BIN_W(8)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & sel),
    .in_ready  (ir_b),
    .bcd_in    (bcd_in),
    .out_valid (ov_b),
    .out_ready (out_ready & sel),
    .bin_out   (bin_b),
    .err_digit (ed_b),
    .err_ovf   (eo_b)
  );

  wire       c_ir  = sel ? ir_b : ir_a;
  wire       c_ov  = sel ? ov_b : ov_a;
  wire       c_ed  = sel ? ed_b : ed_a;
  wire       c_eo  = sel ? eo_b : eo_a;
  wire [9:0] c_bin = sel ? {2'b00, bin_b} : bin_a;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal value from the digits, then range/digit rules
  task automatic model(input logic [11:0] b, input int w,
                       output int eb, output int ed, output int eo);
    int v;
    int maxv;
    ed = (b[3:0] > 9 || b[7:4] > 9 || b[11:8] > 9) ? 1 : 0;
    v = int'(b[3:0]) + 10 * int'(b[7:4]) + 100 * int'(b[11:8]);
    maxv = (1 << w) - 1;
    eo = (!ed && v > maxv) ? 1 : 0;
    if (ed) eb = 0;
    else if (eo) begin
`ifdef BCD2BIN_SAT_EN
      eb = maxv;
`else
      eb = v % (1 << w);
`endif
    end else eb = v;
  endtask

  task automatic start(input logic [11:0] b);
    @(negedge clk);
    chk("in_ready_idle", int'(c_ir), 1);
    in_valid = 1'b1;
    bcd_in = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic finish(input logic [11:0] b, input int bp,
                        input logic [11:0] nb, input bit use_nb);
    int lat;
    int w;
    int eb, ed, eo;
    lat = 0;
    w = sel ? 8 : 10;
    out_ready = (bp == 0);
    model(b, w, eb, ed, eo);
    while (!c_ov && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, w);
    chk("bin_out", int'(c_bin), eb);
    chk("err_digit", int'(c_ed), ed);
    chk("err_ovf", int'(c_eo), eo);
    if (use_nb) begin
      in_valid = 1'b1;
      bcd_in = nb;
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", int'(c_ov), 1);
      chk("bp_bin", int'(c_bin), eb);
      chk("bp_flags", int'({c_ed, c_eo}), (ed << 1) | eo);
      chk("bp_in_ready", int'(c_ir), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("handoff_valid", int'(c_ov), 0);
    chk("handoff_ready", int'(c_ir), 1);
  endtask

  task automatic convert(input logic [11:0] b);
    start(b);
    finish(b, 0, 12'h000, 1'b0);
  endtask

  function automatic logic [11:0] rnd_bcd(input bit allow_bad);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = 4'($urandom_range(0, 9));
    end
    if (allow_bad && $urandom_range(0, 4) == 0) begin
      r[$urandom_range(0, 2)*4 +: 4] = 4'($urandom_range(10, 15));
    end
    return r;
  endfunction

  initial begin
    logic [11:0] r;
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready", int'(ir_a), 1);
    chk("rst_out_valid", int'(ov_a), 0);
    chk("rst_bin", int'(bin_a), 0);
    chk("rst_flags", int'({ed_a, eo_a}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    sel = 1'b0;
    convert(12'h180);
    convert(12'h999);
    convert(12'h000);
    convert(12'h1A0);

    sel = 1'b1;
    convert(12'h256);
    convert(12'h255);
    convert(12'h1A0);
    sel = 1'b0;

    // Backpressure with a second request held high throughout
    start(12'h472);
    finish(12'h472, 20, 12'h618, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    finish(12'h618, 0, 12'h000, 1'b0);

    // Reset during iteration 5
    start(12'h345);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(ov_a), 0);
    chk("midrst_ready", int'(ir_a), 1);
    chk("midrst_bin", int'(bin_a), 0);
    chk("midrst_flags", int'({ed_a, eo_a}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_valid", int'(ov_a), 0);
    end
    convert(12'h345);

    for (int k = 0; k < 24; k++) begin
      sel = k[0];
      r = rnd_bcd(1'b1);
      convert(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
